// File: rtl/hybrid_addsub_pkg.sv
// Shared types and sizing helpers for the sequential hybrid add/subtract unit.
package hybrid_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry into its MSB and carry out.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x_i,
  input  logic [CHUNK-1:0] y_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_c,
  output logic             c_top_c,
  output logic             cout_c
);

  logic [CHUNK:0] total;

  always_comb begin
    total   = {1'b0, x_i} + {1'b0, y_i} + (CHUNK+1)'(cin_i);
    sum_c   = total[CHUNK-1:0];
    cout_c  = total[CHUNK];
    // Carry into the top bit recovered from that bit's sum equation.
    c_top_c = x_i[CHUNK-1] ^ y_i[CHUNK-1] ^ total[CHUNK-1];
  end

endmodule

// File: rtl/hybrid_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock, valid/ready on both sides.
// Optional build macro HYBRID_ADDSUB_SAT_EN clamps overflowing results to signed saturation.
module hybrid_addsub_seq
  import hybrid_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_msb,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = idx_width(NCHUNK);

  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("hybrid_addsub_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] x_sel, y_sel, ch_sum;
  logic             ch_top, ch_cout;
  logic [WIDTH-1:0] s_wr, s_fin;

  // Select the active slice of the latched operands.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDX_W'(k)) begin
        x_sel = a_q[k*CHUNK +: CHUNK];
        y_sel = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x_i    (x_sel),
    .y_i    (y_sel),
    .cin_i  (carry_q),
    .sum_c  (ch_sum),
    .c_top_c(ch_top),
    .cout_c (ch_cout)
  );

  // Result register with the current slice merged in.
  always_comb begin
    s_wr = s_q;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDX_W'(k)) begin
        s_wr[k*CHUNK +: CHUNK] = ch_sum;
      end
    end
`ifdef HYBRID_ADDSUB_SAT_EN
    if (ch_top ^ ch_cout) begin
      s_fin = ch_cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      s_fin = s_wr;
    end
`else
    s_fin = s_wr;
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    s_d       = s_q;
    c_msb_d   = c_msb_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (m == MODE_ADD) ? b : ~b;
          carry_d = (m == MODE_SUB);
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        carry_d = ch_cout;
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          s_d     = s_fin;
          c_msb_d = ch_top;
          cout_d  = ch_cout;
          ovf_d   = ch_top ^ ch_cout;
          state_d = ST_DONE;
        end else begin
          s_d   = s_wr;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      c_msb_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      c_msb_q     <= c_msb_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_msb     = c_msb_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_hybrid_addsub_seq.sv
// Scoreboard bench for hybrid_addsub_seq: a 16/4 and an 8/4 instance against a signed/unsigned arithmetic model.
module tb_hybrid_addsub_seq;

  typedef struct {
    logic [15:0] s;
    logic        c_msb;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  int          rdy_mode;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  logic        iv16, ir16, m16, ov16, cm16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, m8, ov8, cm8, co8, of8;
  logic [7:0]  a8, b8, s8;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e5;
  logic prev16 = 1'b0, prev8 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hybrid_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .m(m16),
    .out_valid(ov16), .out_ready(out_ready), .s(s16), .c_msb(cm16), .cout(co16), .overflow(of16)
  );

  hybrid_addsub_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .m(m8),
    .out_valid(ov8), .out_ready(out_ready), .s(s8), .c_msb(cm8), .cout(co8), .overflow(of8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: exact signed/unsigned arithmetic, then the spec's flag definitions.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic mv);
    exp_t   e;
    longint md, ua, ub, sa, sb, r, full;
    md = longint'(1) << w;
    ua = longint'(av) & (md - 1);
    ub = longint'(bv) & (md - 1);
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    if (mv) begin
      r      = sa - sb;
      full   = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      r      = sa + sb;
      full   = ua + ub;
      e.cout = (full >= md);
    end
    e.ovf   = (r < -(md / 2)) || (r >= md / 2);
    e.c_msb = e.ovf ^ e.cout;
    e.s     = 16'(((full % md) + md) % md);
`ifdef HYBRID_ADDSUB_SAT_EN
    if (e.ovf) e.s = e.cout ? 16'(md / 2) : 16'(md / 2 - 1);
`endif
    e.acc = 0;
    return e;
  endfunction

  function automatic logic unit_ready(input int unit);
    return (unit == 0) ? ir16 : ir8;
  endfunction

  task automatic set_in(input int unit, input logic v, input logic [15:0] av,
                        input logic [15:0] bv, input logic mv);
    if (unit == 0) begin
      iv16 = v; a16 = av; b16 = bv; m16 = mv;
    end else begin
      iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; m8 = mv;
    end
  endtask

  // Present one operation and queue its expected result once the accepting edge is known.
  task automatic drive_op(input int unit, input logic [15:0] av, input logic [15:0] bv,
                          input logic mv);
    exp_t e;
    int   k;
    @(negedge clk);
    set_in(unit, 1'b1, av, bv, mv);
    e = model((unit == 0) ? 16 : 8, av, bv, mv);
    for (k = 0; k < 100; k++) begin
      if (unit_ready(unit)) break;
      @(negedge clk);
    end
    if (k == 100) begin
      flag_fail("accept_timeout");
    end else begin
      e.acc = cyc + 1;
      if (unit == 0) q16.push_back(e); else q8.push_back(e);
    end
    @(posedge clk);
    #1;
    set_in(unit, 1'b0, av, bv, mv);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (q16.size() == 0 && q8.size() == 0) break;
      @(negedge clk);
    end
    if (k == 400) flag_fail("drain_timeout");
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitors: latency on out_valid rise, full result compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov16 && !prev16) begin
        if (q16.size() == 0) flag_fail("w16_unexpected_valid");
        else chk("w16_latency", 32'(cyc - q16[0].acc), 32'd4);
      end
      if (ov16 && out_ready) begin
        if (q16.size() == 0) flag_fail("w16_unexpected_result");
        else begin
          e = q16.pop_front();
          chk("w16_s", 32'(s16), 32'(e.s));
          chk("w16_c_msb", 32'(cm16), 32'(e.c_msb));
          chk("w16_cout", 32'(co16), 32'(e.cout));
          chk("w16_overflow", 32'(of16), 32'(e.ovf));
        end
      end
    end
    prev16 = ov16;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov8 && !prev8) begin
        if (q8.size() == 0) flag_fail("w8_unexpected_valid");
        else chk("w8_latency", 32'(cyc - q8[0].acc), 32'd2);
      end
      if (ov8 && out_ready) begin
        if (q8.size() == 0) flag_fail("w8_unexpected_result");
        else begin
          e = q8.pop_front();
          chk("w8_s", 32'(s8), 32'(e.s));
          chk("w8_c_msb", 32'(cm8), 32'(e.c_msb));
          chk("w8_cout", 32'(co8), 32'(e.cout));
          chk("w8_overflow", 32'(of8), 32'(e.ovf));
        end
      end
    end
    prev8 = ov8;
  end

  function automatic logic [15:0] rnd_operand();
    logic [15:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000; corners[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; rdy_mode = 0; out_ready = 1'b1;
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(1, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready16", 32'(ir16), 32'd1);
    chk("rst_out_valid16", 32'(ov16), 32'd0);
    chk("rst_s16", 32'(s16), 32'd0);
    chk("rst_flags16", {29'd0, cm16, co16, of16}, 32'd0);
    chk("rst_in_ready8", 32'(ir8), 32'd1);
    chk("rst_out_valid8", 32'(ov8), 32'd0);
    chk("rst_s8", 32'(s8), 32'd0);

    // Directed carry / borrow / overflow corners, 16-bit.
    drive_op(0, 16'h0002, 16'h0003, 1'b0);
    drive_op(0, 16'h0000, 16'h0001, 1'b1);
    drive_op(0, 16'h7FFF, 16'h0001, 1'b0);
    drive_op(0, 16'h8000, 16'h0001, 1'b1);
    drain();

    // Back-pressure: result must hold and new operands must wait.
    rdy_mode = 2;
    e5 = model(16, 16'h1234, 16'h0101, 1'b0);
    drive_op(0, 16'h1234, 16'h0101, 1'b0);
    for (int k = 0; k < 20 && !ov16; k++) @(negedge clk);
    if (!ov16) flag_fail("bp_valid_timeout");
    set_in(0, 1'b1, 16'h1111, 16'h0022, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir16), 32'd0);
      chk("bp_out_valid", 32'(ov16), 32'd1);
      chk("bp_s_hold", 32'(s16), 32'(e5.s));
    end
    rdy_mode = 0;
    drive_op(0, 16'h1111, 16'h0022, 1'b1);
    drain();

    // Reset in the middle of a run aborts it.
    drive_op(0, 16'h00FF, 16'h0001, 1'b0);
    void'(q16.pop_back());
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(ov16), 32'd0);
    chk("abort_s", 32'(s16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(ir16), 32'd1);
    chk("abort_cout", 32'(co16), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", 32'(ov16), 32'd0);

    // Same corners at 8 bits.
    drive_op(1, 16'h0002, 16'h0003, 1'b0);
    drive_op(1, 16'h0000, 16'h0001, 1'b1);
    drive_op(1, 16'h007F, 16'h0001, 1'b0);
    drive_op(1, 16'h0080, 16'h0001, 1'b1);
    drain();

    // Random operands under random back-pressure.
    rdy_mode = 1;
    repeat (40) drive_op(0, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
    repeat (40) drive_op(1, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
    drain();
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
